// File: rtl/sum_of_squares_acc.sv
// Block accumulator for squared 3-bit samples: sums COUNT samples with saturation,
// presents each total on a valid/ready output and flags samples that are not legal squares.
module sum_of_squares_acc #(
   parameter int COUNT = 8,
   parameter int SUM_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [5:0]       in_square,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [SUM_W-1:0] out_sum,
   output logic             out_sat,
   output logic             bad_sample
);

   localparam int CNT_W = (COUNT > 1) ? $clog2(COUNT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COUNT - 1);

   typedef enum logic {
      ST_ACC  = 1'b0,
      ST_HOLD = 1'b1
   } state_t;

   function automatic logic is_square(input logic [5:0] v);
      case (v)
         6'd0, 6'd1, 6'd4, 6'd9, 6'd16, 6'd25, 6'd36, 6'd49: is_square = 1'b1;
         default:                                             is_square = 1'b0;
      endcase
   endfunction

   function automatic logic [SUM_W:0] wide_add(input logic [SUM_W-1:0] a,
                                                input logic [5:0]       b);
      wide_add = {1'b0, a} + {{(SUM_W - 5){1'b0}}, b};
   endfunction

   function automatic logic [SUM_W-1:0] saturate(input logic [SUM_W:0] w);
      saturate = w[SUM_W] ? {SUM_W{1'b1}} : w[SUM_W-1:0];
   endfunction

   state_t           state_q, state_d;
   logic [SUM_W-1:0] acc_q, acc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             sat_q, sat_d;
   logic [SUM_W-1:0] out_sum_q, out_sum_d;
   logic             out_sat_q, out_sat_d;
   logic             bad_q, bad_d;

   logic [SUM_W:0]   sum_wide;
   logic             ovf;
   logic             accept;

   // in_ready/out_valid come straight from the state flop, so neither sees in_* or out_ready.
   assign in_ready   = (state_q == ST_ACC);
   assign out_valid  = (state_q == ST_HOLD);
   assign out_sum    = out_sum_q;
   assign out_sat    = out_sat_q;
   assign bad_sample = bad_q;

   // clear suppresses the accept even though in_ready is already high that cycle.
   assign accept   = in_valid && in_ready && !clear;
   assign sum_wide = wide_add(acc_q, in_square);
   assign ovf      = sum_wide[SUM_W];

   always_comb begin
      state_d   = state_q;
      acc_d     = acc_q;
      cnt_d     = cnt_q;
      sat_d     = sat_q;
      out_sum_d = out_sum_q;
      out_sat_d = out_sat_q;
      bad_d     = bad_q;

      if (clear) begin
         state_d   = ST_ACC;
         acc_d     = '0;
         cnt_d     = '0;
         sat_d     = 1'b0;
         out_sum_d = '0;
         out_sat_d = 1'b0;
         bad_d     = 1'b0;
      end else begin
         case (state_q)
            ST_ACC: begin
               if (accept) begin
                  if (!is_square(in_square)) begin
                     bad_d = 1'b1;
                  end
                  if (cnt_q == CNT_LAST) begin
                     out_sum_d = saturate(sum_wide);
                     out_sat_d = sat_q | ovf;
                     state_d   = ST_HOLD;
                     acc_d     = '0;
                     cnt_d     = '0;
                     sat_d     = 1'b0;
                  end else begin
                     acc_d = saturate(sum_wide);
                     sat_d = sat_q | ovf;
                     cnt_d = cnt_q + CNT_W'(1);
                  end
               end
            end
            ST_HOLD: begin
               if (out_ready) begin
                  state_d = ST_ACC;
               end
            end
            default: state_d = ST_ACC;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_ACC;
         acc_q     <= '0;
         cnt_q     <= '0;
         sat_q     <= 1'b0;
         out_sum_q <= '0;
         out_sat_q <= 1'b0;
         bad_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         acc_q     <= acc_d;
         cnt_q     <= cnt_d;
         sat_q     <= sat_d;
         out_sum_q <= out_sum_d;
         out_sat_q <= out_sat_d;
         bad_q     <= bad_d;
      end
   end

endmodule

// File: tb/tb_sum_of_squares_acc.sv
// Directed bench for sum_of_squares_acc: stimulus pushes hand-computed block totals,
// an independent monitor pops and compares them on every output handshake.
module tb_sum_of_squares_acc;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       clear;
   logic       in_valid;
   logic       in_ready;
   logic [5:0] in_square;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_sum;
   logic       out_sat;
   logic       bad_sample;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [7:0] sum;
      logic       sat;
      logic       bad;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;

   sum_of_squares_acc #(.COUNT(8), .SUM_W(8)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .clear      (clear),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_square  (in_square),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_sum    (out_sum),
      .out_sat    (out_sat),
      .bad_sample (bad_sample)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic push_exp(input int sum, input bit sat, input bit bad);
      exp_t e;
      e.sum = 8'(sum);
      e.sat = sat;
      e.bad = bad;
      exp_q.push_back(e);
   endtask

   // Present one sample and return just after the edge that accepts it.
   task automatic send(input logic [5:0] sq);
      int n = 0;
      in_valid  = 1'b1;
      in_square = sq;
      while (!in_ready && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      if (!in_ready) begin
         chk("in_ready_timeout", 0, 1);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic send_n(input logic [5:0] sq, input int n);
      for (int i = 0; i < n; i++) send(sq);
   endtask

   task automatic pulse_clear();
      @(posedge clk); #1;
      clear = 1'b1;
      @(posedge clk); #1;
      clear = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      chk("drain_pending", exp_q.size(), 0);
   endtask

   // Monitor: every output handshake must match the oldest expected total.
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready && !clear) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output: got sum %0d with no expected total", out_sum);
         end else begin
            mon_e = exp_q.pop_front();
            chk("out_sum", int'(out_sum), int'(mon_e.sum));
            chk("out_sat", int'(out_sat), int'(mon_e.sat));
            chk("bad_sample_at_out", int'(bad_sample), int'(mon_e.bad));
         end
      end
   end

   initial begin
      rst_n     = 1'b0;
      clear     = 1'b0;
      in_valid  = 1'b0;
      in_square = '0;
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_in_ready", int'(in_ready), 1);
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_out_sum", int'(out_sum), 0);
      chk("rst_out_sat", int'(out_sat), 0);
      chk("rst_bad", int'(bad_sample), 0);
      rst_n = 1'b1;

      // Normal block of all legal squares: 0+1+4+9+16+25+36+49 = 140.
      push_exp(140, 1'b0, 1'b0);
      send(0); send(1); send(4); send(9);
      send(16); send(25); send(36); send(49);
      chk("normal_valid_after_last", int'(out_valid), 1);
      chk("normal_ready_low_in_hold", int'(in_ready), 0);
      drain();

      // Async reset mid-block (after a bad sample) discards the partial block.
      send(1); send(3); send(1);
      chk("pre_reset_bad", int'(bad_sample), 1);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_in_ready", int'(in_ready), 1);
      chk("async_rst_out_valid", int'(out_valid), 0);
      chk("async_rst_out_sum", int'(out_sum), 0);
      chk("async_rst_bad", int'(bad_sample), 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      push_exp(8, 1'b0, 1'b0);
      send_n(1, 8);
      drain();

      // Saturation: 8*49 = 392 clamps to 255, next block starts clean.
      push_exp(255, 1'b1, 1'b0);
      send_n(49, 8);
      push_exp(8, 1'b0, 1'b0);
      send_n(1, 8);
      drain();

      // Backpressure with a 9 waiting upstream during HOLD.
      out_ready = 1'b0;
      push_exp(32, 1'b0, 1'b0);
      send_n(4, 8);
      in_valid  = 1'b1;
      in_square = 6'd9;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_in_ready_low", int'(in_ready), 0);
         chk("bp_out_valid", int'(out_valid), 1);
         chk("bp_out_sum_stable", int'(out_sum), 32);
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
      push_exp(16, 1'b0, 1'b0);   // held 9 + seven 1s
      send(9);
      send_n(1, 7);
      drain();

      // Illegal sample 33 is accumulated and sets the sticky flag.
      push_exp(33, 1'b0, 1'b1);
      send(33);
      chk("bad_after_accept", int'(bad_sample), 1);
      send_n(0, 7);
      push_exp(0, 1'b0, 1'b1);
      send_n(0, 8);
      drain();
      chk("bad_sticky", int'(bad_sample), 1);

      // clear mid-block restarts the count and drops the flag.
      send_n(4, 3);
      pulse_clear();
      chk("clear_bad", int'(bad_sample), 0);
      chk("clear_out_sum", int'(out_sum), 0);
      chk("clear_in_ready", int'(in_ready), 1);
      push_exp(32, 1'b0, 1'b0);
      send_n(4, 8);
      drain();

      // clear during HOLD discards the pending total.
      out_ready = 1'b0;
      send_n(1, 8);
      @(negedge clk);
      chk("hold_before_clear", int'(out_valid), 1);
      pulse_clear();
      @(negedge clk);
      chk("clear_in_hold_valid", int'(out_valid), 0);
      chk("clear_in_hold_sum", int'(out_sum), 0);
      out_ready = 1'b1;

      // clear in the same cycle as the final sample: no output, count restarts.
      send_n(1, 7);
      in_valid  = 1'b1;
      in_square = 6'd1;
      clear     = 1'b1;
      @(posedge clk); #1;
      clear    = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      chk("clear_final_no_valid", int'(out_valid), 0);
      push_exp(8, 1'b0, 1'b0);
      send_n(1, 8);
      drain();

      repeat (3) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
